// File: rtl/approx_err_monitor.sv
`default_nettype none
// ============================================================================
// approx_err_monitor: error statistics (mismatches, ED sum, max ED) for approximate adders.
// Optional APPROX_ERR_MON_CARRY_EN compares {carry, sum}. Revision: 1.0
// ============================================================================
module approx_err_monitor #(
  parameter int N     = 16,
  parameter int CW    = 24,
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CW-1:0]    num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     op_a,
  input  logic [N-1:0]     op_b,
  input  logic [N-1:0]     approx_sum,
  input  logic             approx_co,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    err_count,
  output logic [ACC_W-1:0] sum_ed,
`ifdef APPROX_ERR_MON_CARRY_EN
  output logic [N:0]       max_ed,
`else
  output logic [N-1:0]     max_ed,
`endif
  output logic [CW-1:0]    sample_count
);

`ifdef APPROX_ERR_MON_CARRY_EN
  localparam int EW = N + 1;
`else
  localparam int EW = N;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     target_q, target_d;
  logic [CW-1:0]     sample_count_q, sample_count_d;
  logic              s1_valid_q, s1_valid_d;
  logic [EW-1:0]     s1_ed_q, s1_ed_d;
  logic              s1_mis_q, s1_mis_d;
  logic [CW-1:0]     err_count_q, err_count_d;
  logic [ACC_W-1:0]  sum_ed_q, sum_ed_d;
  logic [EW-1:0]     max_ed_q, max_ed_d;

  logic [N:0]        exact_full;
  logic [EW-1:0]     exact_cmp;
  logic [EW-1:0]     approx_cmp;
  logic [EW-1:0]     ed_now;
  logic              mis_now;
  logic [ACC_W:0]    sum_ext;
  logic [CW-1:0]     sample_inc;
  logic              accept;

  assign exact_full = {1'b0, op_a} + {1'b0, op_b};

`ifdef APPROX_ERR_MON_CARRY_EN
  assign exact_cmp  = exact_full;
  assign approx_cmp = {approx_co, approx_sum};
`else
  // Carry information plays no part in the N-bit comparison.
  logic [1:0] unused_carry;
  assign unused_carry = {approx_co, exact_full[N]};
  assign exact_cmp    = exact_full[N-1:0];
  assign approx_cmp   = approx_sum;
`endif

  // Plain magnitude distance, deliberately not the modular (wrap-around) one.
  assign ed_now  = (approx_cmp >= exact_cmp) ? (approx_cmp - exact_cmp)
                                             : (exact_cmp - approx_cmp);
  assign mis_now = (approx_cmp != exact_cmp);

  assign accept     = (state_q == S_RUN) && in_valid;
  assign sample_inc = sample_count_q + {{(CW-1){1'b0}}, 1'b1};
  assign sum_ext    = {1'b0, sum_ed_q} + {{(ACC_W+1-EW){1'b0}}, s1_ed_q};

  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    sample_count_d = sample_count_q;
    s1_valid_d     = accept;
    s1_ed_d        = s1_ed_q;
    s1_mis_d       = s1_mis_q;
    err_count_d    = err_count_q;
    sum_ed_d       = sum_ed_q;
    max_ed_d       = max_ed_q;

    if (accept) begin
      s1_ed_d  = ed_now;
      s1_mis_d = mis_now;
    end

    if (s1_valid_q) begin
      err_count_d = err_count_q + {{(CW-1){1'b0}}, s1_mis_q};
      sum_ed_d    = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
      if (s1_ed_q > max_ed_q) begin
        max_ed_d = s1_ed_q;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sample_count_d = '0;
          err_count_d    = '0;
          sum_ed_d       = '0;
          max_ed_d       = '0;
          s1_ed_d        = '0;
          s1_mis_d       = 1'b0;
          if (num_samples != '0) begin
            target_d = num_samples;
            state_d  = S_RUN;
          end else begin
            state_d  = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (accept) begin
          sample_count_d = sample_inc;
          if (sample_inc == target_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      target_q       <= '0;
      sample_count_q <= '0;
      s1_valid_q     <= 1'b0;
      s1_ed_q        <= '0;
      s1_mis_q       <= 1'b0;
      err_count_q    <= '0;
      sum_ed_q       <= '0;
      max_ed_q       <= '0;
    end else begin
      state_q        <= state_d;
      target_q       <= target_d;
      sample_count_q <= sample_count_d;
      s1_valid_q     <= s1_valid_d;
      s1_ed_q        <= s1_ed_d;
      s1_mis_q       <= s1_mis_d;
      err_count_q    <= err_count_d;
      sum_ed_q       <= sum_ed_d;
      max_ed_q       <= max_ed_d;
    end
  end

  assign in_ready     = (state_q == S_RUN);
  assign busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done         = (state_q == S_DONE);
  assign err_count    = err_count_q;
  assign sum_ed       = sum_ed_q;
  assign max_ed       = max_ed_q;
  assign sample_count = sample_count_q;

endmodule
`default_nettype wire
